// File: rtl/serial_xor.sv
// serial_xor: free-running bit-serial XOR of two 1-bit operands.
// Each 4-cycle pass samples {b,a} in CAPTURE, folds a into an
// accumulator in SHIFT0, then folds b in SHIFT1. The result is
// registered on xo, and ready pulses for one cycle in DONE.
// Ports:
//   clk   - rising-edge clock
//   rstn  - asynchronous active-low reset
//   a, b  - operands, sampled only on the edge leaving CAPTURE
//   xo    - registered a^b of the last completed pass
//   ready - registered one-cycle pulse marking a new xo
module serial_xor (
  input  logic clk,
  input  logic rstn,
  input  logic a,
  input  logic b,
  output logic xo,
  output logic ready
);

  localparam int unsigned STATE_W = 3;
  localparam int unsigned SR_W    = 2;

  localparam logic [STATE_W-1:0] IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] CAPTURE = 3'd1;
  localparam logic [STATE_W-1:0] SHIFT0  = 3'd2;
  localparam logic [STATE_W-1:0] SHIFT1  = 3'd3;
  localparam logic [STATE_W-1:0] DONE    = 3'd4;

  logic [STATE_W-1:0] state, state_nxt;
  logic [SR_W-1:0]    sr, sr_nxt;
  logic               acc, acc_nxt;
  logic               xo_nxt;
  logic               ready_nxt;

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      sr    <= '0;
      acc   <= 1'b0;
      xo    <= 1'b0;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      acc   <= acc_nxt;
      xo    <= xo_nxt;
      ready <= ready_nxt;
    end
  end

  // Next-state and next-output logic; xo holds unless a pass completes
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    acc_nxt   = acc;
    xo_nxt    = xo;
    ready_nxt = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        sr_nxt    = {b, a};
        acc_nxt   = 1'b0;
        state_nxt = SHIFT0;
      end
      SHIFT0: begin
        acc_nxt   = acc ^ sr[0];
        sr_nxt    = {1'b0, sr[SR_W-1]};
        state_nxt = SHIFT1;
      end
      SHIFT1: begin
        xo_nxt    = acc ^ sr[0];
        ready_nxt = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = CAPTURE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_xor.sv
// Testbench for serial_xor: random and directed operands, scoreboard of
// expected results keyed on clock edges counted since reset release.
module tb_serial_xor;

  logic clk;
  logic rstn;
  logic a;
  logic b;
  logic xo;
  logic ready;

  int errors = 0;
  int checks = 0;

  // Driver modes: 0 fixed operands, 1 random per cycle, 2 random plus
  // a flip just after every rising edge.
  int   mode  = 0;
  logic fix_a = 1'b0;
  logic fix_b = 1'b0;

  int   edge_cnt = 0;
  logic exp_q[$];
  logic last_xo = 1'b0;

  serial_xor dut (
    .clk   (clk),
    .rstn  (rstn),
    .a     (a),
    .b     (b),
    .xo    (xo),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: edges after release are numbered 1,2,...; operands present
  // on edges 2,6,10,... form an operation whose result appears with ready
  // on edges 4,8,12,...
  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      edge_cnt = 0;
      exp_q.delete();
    end else begin
      edge_cnt++;
      if (edge_cnt % 4 == 2) exp_q.push_back(a ^ b);
    end
  end

  // Monitor: ready timing, result popped from scoreboard, xo stability
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      last_xo = 1'b0;
    end else begin
      chk("ready_timing", int'(ready), int'(edge_cnt >= 4 && edge_cnt % 4 == 0));
      if (ready) begin
        if (exp_q.size() == 0) begin
          chk("result_expected", 0, 1);
        end else begin
          chk("xo_result", int'(xo), int'(exp_q.pop_front()));
        end
        last_xo = xo;
      end else begin
        chk("xo_stable", int'(xo), int'(last_xo));
      end
    end
  end

  // Operand drivers
  initial forever begin
    @(negedge clk);
    if (mode == 0) begin
      a = fix_a;
      b = fix_b;
    end else begin
      a = 1'($urandom_range(1));
      b = 1'($urandom_range(1));
    end
  end

  initial forever begin
    @(posedge clk);
    if (mode == 2) begin
      #1;
      a = ~a;
      b = ~b;
    end
  end

  // Wait for the next ready pulse, bounded
  task automatic wait_ready(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  initial begin
    bit found;
    logic [1:0] va[3];
    logic       vx[3];
    va[0] = 2'b01; vx[0] = 1'b1;   // {b,a} = a=1,b=0
    va[1] = 2'b10; vx[1] = 1'b1;   // a=0,b=1
    va[2] = 2'b11; vx[2] = 1'b0;   // a=1,b=1

    a = 1'b0;
    b = 1'b0;
    rstn = 1'b1;
    #3 rstn = 1'b0;
    #1;
    chk("reset_ready", int'(ready), 0);
    chk("reset_xo", int'(xo), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold_ready", int'(ready), 0);
    chk("reset_hold_xo", int'(xo), 0);
    release_reset();

    // Zero operands: first result on the 4th edge, xo = 0
    wait_ready("first");
    chk("first_edge", edge_cnt, 4);
    chk("first_xo", int'(xo), 0);

    // Remaining operand combinations, one per result
    for (int i = 0; i < 3; i++) begin
      fix_a = va[i][0];
      fix_b = va[i][1];
      wait_ready("vec");
      chk("vec_xo", int'(xo), int'(vx[i]));
    end

    // Random operands over 20+ results
    mode = 1;
    repeat (90) @(posedge clk);

    // Operands flipping around every sampling edge
    mode = 2;
    repeat (40) @(posedge clk);

    // Abort in SHIFT1 with a=1,b=0
    mode  = 0;
    fix_a = 1'b1;
    fix_b = 1'b0;
    wait_ready("pre_abort");
    wait_ready("pre_abort2");
    chk("pre_abort_xo", int'(xo), 1);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (edge_cnt % 4 == 3) found = 1'b1;
    end
    if (!found) chk("find_shift1", 0, 1);
    #1 rstn = 1'b0;
    #1;
    chk("abort_ready", int'(ready), 0);
    chk("abort_xo", int'(xo), 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_hold_ready", int'(ready), 0);
    end
    release_reset();
    wait_ready("restart");
    chk("restart_edge", edge_cnt, 4);
    chk("restart_xo", int'(xo), 1);

    mode = 1;
    repeat (20) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
